// File: rtl/pipeline_sequencer_if.sv
// Sequencer control bundle between the debug unit / decode stage and the
// pipeline-register enables.
//   Inputs to the sequencer : I_PS_START, I_PS_MODE, I_PS_STEP, ID/EX hazard
//                             fields, I_PS_TAKEN
//   Outputs from sequencer  : PC / IF-ID / ID-EX / pipe enables, HALTED,
//                             STEP_DONE, executed-cycle counter
// master : the side that drives the requests and watches the enables
// slave  : the sequencer itself
interface pipeline_sequencer_if #(
  parameter int CYC_W = 32
);
  logic             I_PS_START;
  logic             I_PS_MODE;
  logic             I_PS_STEP;
  logic [5:0]       I_PS_ID_OP;
  logic [4:0]       I_PS_ID_RS;
  logic [4:0]       I_PS_ID_RT;
  logic             I_PS_IDEX_MEMREAD;
  logic [4:0]       I_PS_IDEX_RT;
  logic             I_PS_TAKEN;
  logic             O_PS_PC_EN;
  logic             O_PS_IFID_EN;
  logic             O_PS_IFID_FLUSH;
  logic             O_PS_IDEX_BUBBLE;
  logic             O_PS_PIPE_EN;
  logic             O_PS_HALTED;
  logic             O_PS_STEP_DONE;
  logic [CYC_W-1:0] O_PS_CYCLES;

  modport master (
    output I_PS_START, I_PS_MODE, I_PS_STEP, I_PS_ID_OP, I_PS_ID_RS, I_PS_ID_RT,
           I_PS_IDEX_MEMREAD, I_PS_IDEX_RT, I_PS_TAKEN,
    input  O_PS_PC_EN, O_PS_IFID_EN, O_PS_IFID_FLUSH, O_PS_IDEX_BUBBLE,
           O_PS_PIPE_EN, O_PS_HALTED, O_PS_STEP_DONE, O_PS_CYCLES
  );

  modport slave (
    input  I_PS_START, I_PS_MODE, I_PS_STEP, I_PS_ID_OP, I_PS_ID_RS, I_PS_ID_RT,
           I_PS_IDEX_MEMREAD, I_PS_IDEX_RT, I_PS_TAKEN,
    output O_PS_PC_EN, O_PS_IFID_EN, O_PS_IFID_FLUSH, O_PS_IDEX_BUBBLE,
           O_PS_PIPE_EN, O_PS_HALTED, O_PS_STEP_DONE, O_PS_CYCLES
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/stall/flush/halt sequencer for the 5-stage MIPS pipeline.
//   I_CLK   : system clock, rising edge
//   I_RST_N : asynchronous reset, active-low
//   ps      : sequencer bundle (slave side), see pipeline_sequencer_if
// Enables are combinational from state and the ID/EX fields so a load-use
// stall or a taken-branch flush takes effect in the same cycle. HALTED,
// STEP_DONE and the cycle counter are registered.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CYC_W        = 32
) (
  input  logic I_CLK,
  input  logic I_RST_N,
  pipeline_sequencer_if.slave ps
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STEP_WAIT = 3'd2;
  localparam logic [2:0] S_STEP      = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_HALTED    = 3'd5;

  localparam logic [5:0] OP_HALT = 6'b010101;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             halted_q, halted_d;
  logic             done_q, done_d;

  logic hazard, is_halt;
  logic pc_en, ifid_en, flush, bubble, pipe_en;

  // Load in EX whose destination feeds a source of the instruction in ID.
  // $zero never creates a dependency.
  assign hazard  = ps.I_PS_IDEX_MEMREAD && (ps.I_PS_IDEX_RT != 5'd0) &&
                   ((ps.I_PS_IDEX_RT == ps.I_PS_ID_RS) ||
                    (ps.I_PS_IDEX_RT == ps.I_PS_ID_RT));
  assign is_halt = (ps.I_PS_ID_OP == OP_HALT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pc_en   = 1'b0;
    ifid_en = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    pipe_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ps.I_PS_START) state_d = ps.I_PS_MODE ? S_STEP_WAIT : S_RUN;
      end
      S_STEP_WAIT: begin
        if (ps.I_PS_STEP) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        pipe_en = 1'b1;
        if (hazard) begin
          // Stall wins over a taken branch; the branch re-resolves next cycle.
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bubble  = 1'b1;
        end else if (is_halt) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
        end else if (ps.I_PS_TAKEN) begin
          flush   = 1'b1;
        end
        if (!hazard && is_halt) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end else if (state_q == S_STEP) begin
          // A stalled step still completes as one step.
          state_d = S_STEP_WAIT;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        bubble  = 1'b1;
        pipe_en = 1'b1;
        if (cnt_q == '0) state_d = S_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALTED);
    cyc_d    = (pipe_en && (cyc_q != '1)) ? cyc_q + 1'b1 : cyc_q;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cyc_q    <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  assign ps.O_PS_PC_EN       = pc_en;
  assign ps.O_PS_IFID_EN     = ifid_en;
  assign ps.O_PS_IFID_FLUSH  = flush;
  assign ps.O_PS_IDEX_BUBBLE = bubble;
  assign ps.O_PS_PIPE_EN     = pipe_en;
  assign ps.O_PS_HALTED      = halted_q;
  assign ps.O_PS_STEP_DONE   = done_q;
  assign ps.O_PS_CYCLES      = cyc_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a behavioural model of the sequencer rules.
module tb_pipeline_sequencer;
  localparam int D = 4;
  localparam int CW = 32;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b010101;

  logic clk, rst_n;
  int total, bad;

  pipeline_sequencer_if #(.CYC_W(CW)) ps_if ();

  pipeline_sequencer #(.DRAIN_CYCLES(D), .CYC_W(CW)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .ps(ps_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 run, 2 waiting for step, 3 stepping, 4 draining, 5 halted
  int          m_phase, m_left;
  logic [CW-1:0] m_cyc;
  logic        m_halted, m_done;
  logic        m_hz;
  logic [4:0]  m_en;   // {pc, ifid, flush, bubble, pipe}

  assign m_hz = ps_if.I_PS_IDEX_MEMREAD && ps_if.I_PS_IDEX_RT != 0 &&
                (ps_if.I_PS_IDEX_RT == ps_if.I_PS_ID_RS || ps_if.I_PS_IDEX_RT == ps_if.I_PS_ID_RT);

  always_comb begin
    m_en = 5'b00000;
    if (m_phase == 1 || m_phase == 3) begin
      if (m_hz)                              m_en = 5'b00011;
      else if (ps_if.I_PS_ID_OP == OP_HALT)  m_en = 5'b00001;
      else if (ps_if.I_PS_TAKEN)             m_en = 5'b11101;
      else                                   m_en = 5'b11001;
    end else if (m_phase == 4) begin
      m_en = 5'b00011;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_cyc <= '0; m_halted <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done   <= 1'b0;
      m_halted <= (m_phase == 5) || (m_phase == 4 && m_left == 0);
      if (m_en[0] && m_cyc != {CW{1'b1}}) m_cyc <= m_cyc + 1;
      case (m_phase)
        0: if (ps_if.I_PS_START) m_phase <= ps_if.I_PS_MODE ? 2 : 1;
        2: if (ps_if.I_PS_STEP) m_phase <= 3;
        1, 3: begin
          if (!m_hz && ps_if.I_PS_ID_OP == OP_HALT) begin
            m_phase <= 4; m_left <= D - 1;
          end else if (m_phase == 3) begin
            m_phase <= 2; m_done <= 1'b1;
          end
        end
        4: if (m_left == 0) m_phase <= 5; else m_left <= m_left - 1;
        default: ;
      endcase
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  function automatic logic [4:0] dut_en();
    return {ps_if.O_PS_PC_EN, ps_if.O_PS_IFID_EN, ps_if.O_PS_IFID_FLUSH,
            ps_if.O_PS_IDEX_BUBBLE, ps_if.O_PS_PIPE_EN};
  endfunction

  task automatic clear_in();
    ps_if.I_PS_START = 0; ps_if.I_PS_MODE = 0; ps_if.I_PS_STEP = 0;
    ps_if.I_PS_ID_OP = OP_ADDI; ps_if.I_PS_ID_RS = 5'd1; ps_if.I_PS_ID_RT = 5'd2;
    ps_if.I_PS_IDEX_MEMREAD = 0; ps_if.I_PS_IDEX_RT = 5'd0; ps_if.I_PS_TAKEN = 0;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    adv();
  endtask

  // Start in continuous mode and move into the first RUN cycle.
  task automatic start_run();
    ps_if.I_PS_START = 1; ps_if.I_PS_MODE = 0;
    adv();
    ps_if.I_PS_START = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    #3;
    total++;
    if (dut_en() !== 5'b0 || ps_if.O_PS_HALTED !== 0 || ps_if.O_PS_STEP_DONE !== 0 || ps_if.O_PS_CYCLES !== 0) begin
      bad++; $display("FAIL reset_outputs: en=%b halted=%b done=%b cyc=%0d want all 0",
                      dut_en(), ps_if.O_PS_HALTED, ps_if.O_PS_STEP_DONE, ps_if.O_PS_CYCLES);
    end
    do_reset();
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b0) begin bad++; $display("FAIL idle_enables: en=%b want 00000", dut_en()); end
  endtask

  task automatic test_run();
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (dut_en() !== 5'b11001) begin bad++; $display("FAIL run_en[%0d]: en=%b want 11001", i, dut_en()); end
      total++;
      if (ps_if.O_PS_CYCLES !== CW'(i)) begin bad++; $display("FAIL run_cycles[%0d]: got %0d want %0d", i, ps_if.O_PS_CYCLES, i); end
      adv();
    end
  endtask

  task automatic test_hazard();
    ps_if.I_PS_IDEX_MEMREAD = 1; ps_if.I_PS_IDEX_RT = 5'd5; ps_if.I_PS_ID_RS = 5'd5;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b00011) begin bad++; $display("FAIL hazard_rs: en=%b want 00011", dut_en()); end
    adv();
    ps_if.I_PS_ID_RS = 5'd1; ps_if.I_PS_ID_RT = 5'd5;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b00011) begin bad++; $display("FAIL hazard_rt: en=%b want 00011", dut_en()); end
    adv();
    ps_if.I_PS_IDEX_RT = 5'd0; ps_if.I_PS_ID_RS = 5'd0; ps_if.I_PS_ID_RT = 5'd0;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b11001) begin bad++; $display("FAIL hazard_zero_reg: en=%b want 11001", dut_en()); end
    adv();
    clear_in();
  endtask

  task automatic test_taken();
    ps_if.I_PS_TAKEN = 1;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b11101) begin bad++; $display("FAIL taken_flush: en=%b want 11101", dut_en()); end
    adv();
    ps_if.I_PS_TAKEN = 0;
    @(negedge clk);
    total++;
    if (ps_if.O_PS_IFID_FLUSH !== 1'b0) begin bad++; $display("FAIL taken_one_cycle: flush=%b want 0", ps_if.O_PS_IFID_FLUSH); end
    adv();
    ps_if.I_PS_TAKEN = 1; ps_if.I_PS_IDEX_MEMREAD = 1; ps_if.I_PS_IDEX_RT = 5'd7; ps_if.I_PS_ID_RT = 5'd7;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b00011) begin bad++; $display("FAIL taken_with_hazard: en=%b want 00011", dut_en()); end
    adv();
    clear_in();
  endtask

  task automatic test_halt();
    logic [CW-1:0] frozen;
    ps_if.I_PS_ID_OP = OP_HALT;
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b00001) begin bad++; $display("FAIL halt_issue: en=%b want 00001", dut_en()); end
    adv();
    ps_if.I_PS_ID_OP = OP_ADDI;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      total++;
      if (dut_en() !== 5'b00011 || ps_if.O_PS_HALTED !== 1'b0) begin
        bad++; $display("FAIL drain[%0d]: en=%b halted=%b want 00011/0", i, dut_en(), ps_if.O_PS_HALTED);
      end
      adv();
    end
    @(negedge clk);
    total++;
    if (ps_if.O_PS_HALTED !== 1'b1 || dut_en() !== 5'b0) begin
      bad++; $display("FAIL halted_enter: halted=%b en=%b want 1/00000", ps_if.O_PS_HALTED, dut_en());
    end
    total++;
    if (ps_if.O_PS_CYCLES !== m_cyc) begin bad++; $display("FAIL halt_cycles: got %0d want %0d", ps_if.O_PS_CYCLES, m_cyc); end
    frozen = m_cyc;
    ps_if.I_PS_START = 1; ps_if.I_PS_STEP = 1;
    repeat (5) adv();
    @(negedge clk);
    total++;
    if (ps_if.O_PS_HALTED !== 1'b1 || dut_en() !== 5'b0 || ps_if.O_PS_CYCLES !== frozen) begin
      bad++; $display("FAIL halted_sticky: halted=%b en=%b cyc=%0d want 1/00000/%0d",
                      ps_if.O_PS_HALTED, dut_en(), ps_if.O_PS_CYCLES, frozen);
    end
    clear_in();
  endtask

  task automatic test_step();
    do_reset();
    ps_if.I_PS_START = 1; ps_if.I_PS_MODE = 1;
    adv();
    clear_in();
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 4; j++) begin
        ps_if.I_PS_STEP = (j == 0);
        ps_if.I_PS_START = (j == 3);   // must be ignored while stepping
        @(negedge clk);
        total++;
        if (ps_if.O_PS_PIPE_EN !== (j == 1) || ps_if.O_PS_STEP_DONE !== (j == 2)) begin
          bad++; $display("FAIL step[%0d.%0d]: pipe=%b done=%b want %0d/%0d",
                          p, j, ps_if.O_PS_PIPE_EN, ps_if.O_PS_STEP_DONE, (j == 1), (j == 2));
        end
        adv();
      end
    end
    clear_in();
    @(negedge clk);
    total++;
    if (ps_if.O_PS_CYCLES !== CW'(3)) begin bad++; $display("FAIL step_cycles: got %0d want 3", ps_if.O_PS_CYCLES); end
    adv();
  endtask

  task automatic test_reset_drain();
    do_reset();
    start_run();
    adv();
    ps_if.I_PS_ID_OP = OP_HALT;
    adv();
    ps_if.I_PS_ID_OP = OP_ADDI;
    adv();               // now in the 2nd drain cycle
    #2;
    total++;
    if (dut_en() !== 5'b00011) begin bad++; $display("FAIL drain2_pre: en=%b want 00011", dut_en()); end
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_en() !== 5'b0 || ps_if.O_PS_HALTED !== 0 || ps_if.O_PS_STEP_DONE !== 0 || ps_if.O_PS_CYCLES !== 0) begin
      bad++; $display("FAIL reset_in_drain: en=%b halted=%b done=%b cyc=%0d want all 0",
                      dut_en(), ps_if.O_PS_HALTED, ps_if.O_PS_STEP_DONE, ps_if.O_PS_CYCLES);
    end
    @(negedge clk); rst_n = 1'b1;
    adv();
    repeat (3) adv();
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b0 || ps_if.O_PS_HALTED !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: en=%b halted=%b want 00000/0", dut_en(), ps_if.O_PS_HALTED);
    end
    adv();
    start_run();
    @(negedge clk);
    total++;
    if (dut_en() !== 5'b11001) begin bad++; $display("FAIL restart_run: en=%b want 11001", dut_en()); end
    adv();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int e = 0; e < 8; e++) begin
      logic mode;
      mode = e[0];
      do_reset();
      for (int c = 0; c < 120; c++) begin
        ps_if.I_PS_START        = ($urandom_range(0, 7) == 0);
        ps_if.I_PS_MODE         = mode;
        ps_if.I_PS_STEP         = ($urandom_range(0, 2) == 0);
        ps_if.I_PS_ID_OP        = (!mode && $urandom_range(0, 39) == 0) ? OP_HALT : 6'($urandom_range(0, 20));
        ps_if.I_PS_ID_RS        = 5'($urandom_range(0, 3));
        ps_if.I_PS_ID_RT        = 5'($urandom_range(0, 3));
        ps_if.I_PS_IDEX_MEMREAD = ($urandom_range(0, 2) == 0);
        ps_if.I_PS_IDEX_RT      = 5'($urandom_range(0, 3));
        ps_if.I_PS_TAKEN        = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        total++;
        if (dut_en() !== m_en || ps_if.O_PS_HALTED !== m_halted ||
            ps_if.O_PS_STEP_DONE !== m_done || ps_if.O_PS_CYCLES !== m_cyc) begin
          bad++;
          if (errs < 10)
            $display("FAIL random[%0d.%0d]: en=%b halted=%b done=%b cyc=%0d want en=%b halted=%b done=%b cyc=%0d",
                     e, c, dut_en(), ps_if.O_PS_HALTED, ps_if.O_PS_STEP_DONE, ps_if.O_PS_CYCLES,
                     m_en, m_halted, m_done, m_cyc);
          errs++;
        end
        adv();
      end
    end
    clear_in();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_run();
    test_hazard();
    test_taken();
    test_halt();
    test_step();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end
endmodule
